fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-002 SHALL have reset_n, input, 1, asynchronous, active-low reset.
REQ-003 SHALL have pc_write, input, 1, from the hazard unit; 0 holds the PC.
REQ-004 SHALL have ir_write, input, 1, from the hazard unit; 0 holds IR, ir_pc_next and ir_valid.
REQ-005 SHALL have flush_if, input, 1, from the hazard unit; discards the fetched instruction.
REQ-006 SHALL have redirect_pc, input, 16, the corrected PC, valid when flush_if=1.
REQ-007 SHALL have i_readM, output, 1, the instruction-memory read request.
REQ-008 SHALL have i_address, output, 16, the read address; equals PC.
REQ-009 SHALL have i_ready, input, 1, high for one cycle when i_data is valid.
REQ-010 SHALL have i_data, input, 16, the instruction word.
REQ-011 SHALL have ir, output, 16, the instruction register feeding ID.
REQ-012 SHALL have ir_pc_next, output, 16, the PC+1 of the instruction in ir.
REQ-013 SHALL have ir_valid, output, 1, 1 when ir holds a real instruction, 0 for a NOP bubble.
REQ-014 SHALL have pred_taken, output, 1, the BTB hit recorded with ir.
REQ-015 SHALL have btb_wr, input, 1, the BTB update strobe from ID/EX.
REQ-016 SHALL have btb_wr_pc, input, 16, the PC of the resolved branch or jump.
REQ-017 SHALL have btb_wr_target, input, 16, the taken target of that branch or jump.

Function
REQ-018 SHALL implement FSM REQ (request outstanding) / HOLD (word buffered, ID stalled).
REQ-019 In REQ, SHALL drive i_readM=1 and i_address=PC; in HOLD, SHALL drive i_readM=0.
REQ-020 SHALL compute next_pc as: BTB hit -> stored target; otherwise PC+1, modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-021 REQ, i_ready=1, ir_write=1: ir<=i_data, ir_valid<=1, ir_pc_next<=PC+1, pred_taken<=hit; if pc_write, PC<=next_pc; stay in REQ.
REQ-022 REQ, i_ready=1, ir_write=0: SHALL latch i_data, next_pc and hit into a hold buffer, leave ir unchanged, and go to HOLD.
REQ-023 HOLD, ir_write=1: ir<=buffered word, ir_valid<=1, PC<=buffered next_pc, go to REQ.
REQ-024 REQ, i_ready=0, ir_write=1: SHALL load ir with the shared-constants NOP word, set ir_valid<=0, and leave PC unchanged.
REQ-025 flush_if=1 SHALL override all of the above: PC<=redirect_pc, ir<=NOP, ir_valid<=0, pred_taken<=0, hold buffer discarded, FSM<=REQ, and any i_data returned that cycle dropped.
REQ-026 Priority SHALL be reset > flush_if > ir_write=0 stall > normal fetch.
REQ-027 The BTB SHALL be 4 entries, direct-mapped, indexed by PC[1:0], each entry holding valid, tag PC[15:2] and target[15:0]; hit = valid && tag match.
REQ-028 btb_wr SHALL write the entry {1, btb_wr_pc[15:2], btb_wr_target} at index btb_wr_pc[1:0].
REQ-029 A simultaneous btb_wr and lookup at the same index SHALL return the old entry; the new entry is visible next cycle.
REQ-030 Fetch latency SHALL be one cycle after i_ready, with no combinational path from i_data to ir.

Reset
REQ-031 reset_n=0 SHALL asynchronously set PC=0x0000, ir=NOP, ir_valid=0, ir_pc_next=0, pred_taken=0, FSM=REQ, all BTB valid bits=0, hold buffer empty.
REQ-032 While reset_n=0, SHALL force i_readM=0; the first request SHALL issue in the first cycle after release.
REQ-033 Reset asserted mid-request SHALL abandon the request, and any later i_ready SHALL be ignored until i_readM is reasserted.

Configuration
REQ-034 With macro FETCH_BTB_EN defined, SHALL implement the BTB and prediction as specified.
REQ-035 Without FETCH_BTB_EN, next_pc SHALL be PC+1, pred_taken SHALL be 0, btb_wr SHALL be ignored, and no BTB storage SHALL be synthesised.

Verification
REQ-036 Reset release, memory returns 0x1111 at addr 0: next cycle ir=0x1111, ir_valid=1, ir_pc_next=0x0001, i_address=0x0001.
REQ-037 i_ready=1 with ir_write=0 for 2 cycles: FSM=HOLD, i_readM=0, ir unchanged; on ir_write=1, ir=the buffered word, i_address advances by 1.
REQ-038 flush_if=1 with redirect_pc=0x0040 while i_ready=1: ir=NOP, ir_valid=0, next i_address=0x0040, returned word dropped.
REQ-039 FETCH_BTB_EN, btb_wr pc=0x0005 target=0x0020, then fetch at 0x0005: pred_taken=1 with that ir, next i_address=0x0020; without the macro, next i_address=0x0006.
REQ-040 Fetch at 0xFFFF with no BTB hit: next i_address=0x0000, ir_pc_next=0x0000.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with optional 4-entry direct-mapped BTB.
// Optional feature macro: FETCH_BTB_EN (BTB storage and next-PC prediction).
// Without the macro, next_pc is PC+1, pred_taken stays 0 and btb_wr is ignored.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_REQ  | read request outstanding at PC, waiting for i_ready
// ST_HOLD | returned word buffered because ID is stalled (ir_write=0)
module fetch_unit #(
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pc_write,
  input  logic        ir_write,
  input  logic        flush_if,
  input  logic [15:0] redirect_pc,
  output logic        i_readM,
  output logic [15:0] i_address,
  input  logic        i_ready,
  input  logic [15:0] i_data,
  output logic [15:0] ir,
  output logic [15:0] ir_pc_next,
  output logic        ir_valid,
  output logic        pred_taken,
  input  logic        btb_wr,
  input  logic [15:0] btb_wr_pc,
  input  logic [15:0] btb_wr_target
);

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pc_inc;
  logic [15:0] next_pc;
  logic        btb_hit;
  logic [15:0] btb_target;

  logic [15:0] ir_d, ir_pc_next_d;
  logic        ir_valid_d, pred_taken_d;

  logic [15:0] hold_word_q, hold_word_d;
  logic [15:0] hold_next_q, hold_next_d;
  logic        hold_hit_q, hold_hit_d;

  assign pc_inc    = pc_q + 16'd1;
  assign i_address = pc_q;

  // The request is gated by reset so nothing is issued while reset is held;
  // the first request appears in the first cycle after release.
  assign i_readM = reset_n && (state_q == ST_REQ);

`ifdef FETCH_BTB_EN
  logic [3:0]  btb_valid_q;
  logic [13:0] btb_tag_q [4];
  logic [15:0] btb_tgt_q [4];
  logic [1:0]  lookup_idx;
  logic [1:0]  wr_idx;

  assign lookup_idx = pc_q[1:0];
  assign wr_idx     = btb_wr_pc[1:0];
  assign btb_hit    = btb_valid_q[lookup_idx] && (btb_tag_q[lookup_idx] == pc_q[15:2]);
  assign btb_target = btb_tgt_q[lookup_idx];

  // Valid bits are the only BTB state that needs reset; a same-cycle write is
  // seen by the lookup only on the following cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btb_valid_q <= '0;
    end else if (btb_wr) begin
      btb_valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and target payload, qualified by the valid bits above.
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      btb_tag_q[wr_idx] <= btb_wr_pc[15:2];
      btb_tgt_q[wr_idx] <= btb_wr_target;
    end
  end
`else
  logic unused_btb;

  assign unused_btb = ^{btb_wr, btb_wr_pc, btb_wr_target};
  assign btb_hit    = 1'b0;
  assign btb_target = 16'h0000;
`endif

  assign next_pc = btb_hit ? btb_target : pc_inc;

  // Next-state and datapath decode; flush wins over stall and normal fetch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir;
    ir_pc_next_d  = ir_pc_next;
    ir_valid_d    = ir_valid;
    pred_taken_d  = pred_taken;
    hold_word_d   = hold_word_q;
    hold_next_d   = hold_next_q;
    hold_hit_d    = hold_hit_q;

    if (flush_if) begin
      state_d      = ST_REQ;
      pc_d         = redirect_pc;
      ir_d         = NOP_WORD;
      ir_valid_d   = 1'b0;
      pred_taken_d = 1'b0;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (i_ready) begin
            if (ir_write) begin
              ir_d         = i_data;
              ir_valid_d   = 1'b1;
              ir_pc_next_d = pc_inc;
              pred_taken_d = btb_hit;
              if (pc_write) begin
                pc_d = next_pc;
              end
            end else begin
              hold_word_d = i_data;
              hold_next_d = next_pc;
              hold_hit_d  = btb_hit;
              state_d     = ST_HOLD;
            end
          end else if (ir_write) begin
            ir_d         = NOP_WORD;
            ir_valid_d   = 1'b0;
            pred_taken_d = 1'b0;
          end
        end
        ST_HOLD: begin
          // PC has not moved since the word was buffered, so PC+1 is still
          // the fall-through address of the buffered instruction.
          if (ir_write) begin
            ir_d         = hold_word_q;
            ir_valid_d   = 1'b1;
            ir_pc_next_d = pc_inc;
            pred_taken_d = hold_hit_q;
            pc_d         = hold_next_q;
            state_d      = ST_REQ;
          end
        end
        default: begin
          state_d = ST_REQ;
        end
      endcase
    end
  end

  // State, PC, IR and hold-buffer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_REQ;
      pc_q        <= 16'h0000;
      ir          <= NOP_WORD;
      ir_pc_next  <= 16'h0000;
      ir_valid    <= 1'b0;
      pred_taken  <= 1'b0;
      hold_word_q <= 16'h0000;
      hold_next_q <= 16'h0000;
      hold_hit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir          <= ir_d;
      ir_pc_next  <= ir_pc_next_d;
      ir_valid    <= ir_valid_d;
      pred_taken  <= pred_taken_d;
      hold_word_q <= hold_word_d;
      hold_next_q <= hold_next_d;
      hold_hit_q  <= hold_hit_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a
// behavioural model of the fetch rules (buffered word, PC, direct-mapped BTB).
module tb_fetch_unit;

  localparam logic [15:0] NOP = 16'h0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pc_write, ir_write, flush_if;
  logic [15:0] redirect_pc;
  logic        i_readM;
  logic [15:0] i_address;
  logic        i_ready;
  logic [15:0] i_data;
  logic [15:0] ir, ir_pc_next;
  logic        ir_valid, pred_taken;
  logic        btb_wr;
  logic [15:0] btb_wr_pc, btb_wr_target;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pc_write     (pc_write),
    .ir_write     (ir_write),
    .flush_if     (flush_if),
    .redirect_pc  (redirect_pc),
    .i_readM      (i_readM),
    .i_address    (i_address),
    .i_ready      (i_ready),
    .i_data       (i_data),
    .ir           (ir),
    .ir_pc_next   (ir_pc_next),
    .ir_valid     (ir_valid),
    .pred_taken   (pred_taken),
    .btb_wr       (btb_wr),
    .btb_wr_pc    (btb_wr_pc),
    .btb_wr_target(btb_wr_target)
  );

  // Behavioural model state
  logic [15:0] m_pc, m_ir, m_pcn;
  logic        m_valid, m_pred;
  bit          m_rst;
  bit          m_held;
  logic [15:0] m_hword, m_hnext;
  logic        m_hhit;
  bit          m_bv [4];
  logic [15:0] m_bpc [4];
  logic [15:0] m_btgt [4];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_ir = NOP; m_pcn = 16'h0000;
    m_valid = 1'b0; m_pred = 1'b0; m_held = 1'b0;
    for (int i = 0; i < 4; i++) m_bv[i] = 1'b0;
  endtask

  // One rising edge of the fetch rules, given the inputs currently applied.
  task automatic model_step();
    bit          hit;
    int          k;
    logic [15:0] nxt;
    k   = int'(m_pc[1:0]);
    hit = 1'b0;
`ifdef FETCH_BTB_EN
    hit = m_bv[k] && (m_bpc[k] == m_pc);
`endif
    nxt = hit ? m_btgt[k] : 16'(m_pc + 16'd1);
    if (flush_if) begin
      m_pc = redirect_pc; m_ir = NOP; m_valid = 1'b0; m_pred = 1'b0; m_held = 1'b0;
    end else if (m_held) begin
      if (ir_write) begin
        m_ir = m_hword; m_valid = 1'b1; m_pred = m_hhit;
        m_pcn = 16'(m_pc + 16'd1); m_pc = m_hnext; m_held = 1'b0;
      end
    end else if (i_ready) begin
      if (ir_write) begin
        m_ir = i_data; m_valid = 1'b1; m_pred = hit; m_pcn = 16'(m_pc + 16'd1);
        if (pc_write) m_pc = nxt;
      end else begin
        m_hword = i_data; m_hnext = nxt; m_hhit = hit; m_held = 1'b1;
      end
    end else if (ir_write) begin
      m_ir = NOP; m_valid = 1'b0; m_pred = 1'b0;
    end
`ifdef FETCH_BTB_EN
    if (btb_wr) begin
      m_bv[int'(btb_wr_pc[1:0])]   = 1'b1;
      m_bpc[int'(btb_wr_pc[1:0])]  = btb_wr_pc;
      m_btgt[int'(btb_wr_pc[1:0])] = btb_wr_target;
    end
`endif
  endtask

  task automatic compare();
    chk("i_readM", i_readM, (!m_rst && !m_held));
    chk("i_address", i_address, m_pc);
    chk("ir", ir, m_ir);
    chk("ir_valid", ir_valid, m_valid);
    if (m_valid) begin
      chk("ir_pc_next", ir_pc_next, m_pcn);
      chk("pred_taken", pred_taken, m_pred);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic set_in(input logic pcw, input logic irw, input logic fl, input logic [15:0] rdr,
                        input logic rdy, input logic [15:0] dat,
                        input logic bw, input logic [15:0] bpc, input logic [15:0] btg);
    pc_write = pcw; ir_write = irw; flush_if = fl; redirect_pc = rdr;
    i_ready = rdy; i_data = dat; btb_wr = bw; btb_wr_pc = bpc; btb_wr_target = btg;
  endtask

  task automatic drive_random();
    pc_write    = ($urandom_range(0, 7) != 0);
    ir_write    = ($urandom_range(0, 3) != 0);
    flush_if    = ($urandom_range(0, 15) == 0);
    redirect_pc = ($urandom_range(0, 7) == 0) ? 16'(16'hFFFC + 16'($urandom_range(0, 3)))
                                               : 16'($urandom_range(0, 63));
    i_ready     = 1'($urandom_range(0, 1));
    i_data      = 16'($urandom);
    btb_wr      = ($urandom_range(0, 3) == 0);
    btb_wr_pc   = 16'(m_pc + 16'($urandom_range(0, 3)));
    btb_wr_target = 16'($urandom_range(0, 63));
  endtask

  initial begin
    reset_n = 1'b0;
    m_rst   = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'h0000, 16'h0000);
    model_reset();
    #2;
    chk("rst_i_readM", i_readM, 1'b0);
    chk("rst_ir", ir, NOP);
    chk("rst_ir_valid", ir_valid, 1'b0);
    chk("rst_ir_pc_next", ir_pc_next, 16'h0000);
    chk("rst_pred_taken", pred_taken, 1'b0);
    chk("rst_i_address", i_address, 16'h0000);
    @(negedge clk);
    compare();

    // First fetch after release
    reset_n = 1'b1; m_rst = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1111, 1'b0, 16'h0000, 16'h0000);
    cycle();
    chk("first_ir", ir, 16'h1111);
    chk("first_valid", ir_valid, 1'b1);
    chk("first_pcn", ir_pc_next, 16'h0001);
    chk("first_addr", i_address, 16'h0001);

    // ID stalled while a word returns: buffered, request dropped
    set_in(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b0, 16'h0000, 16'h0000);
    cycle();
    chk("hold_readM", i_readM, 1'b0);
    chk("hold_ir", ir, 16'h1111);
    set_in(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hDEAD, 1'b0, 16'h0000, 16'h0000);
    cycle();
    chk("hold2_readM", i_readM, 1'b0);
    chk("hold2_ir", ir, 16'h1111);
    set_in(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    cycle();
    chk("release_ir", ir, 16'h2222);
    chk("release_valid", ir_valid, 1'b1);
    chk("release_addr", i_address, 16'h0002);
    chk("release_readM", i_readM, 1'b1);

    // Flush while a word returns: word dropped
    set_in(1'b1, 1'b1, 1'b1, 16'h0040, 1'b1, 16'h3333, 1'b0, 16'h0000, 16'h0000);
    cycle();
    chk("flush_ir", ir, NOP);
    chk("flush_valid", ir_valid, 1'b0);
    chk("flush_pred", pred_taken, 1'b0);
    chk("flush_addr", i_address, 16'h0040);

    // BTB entry for 0x0005 -> 0x0020, then fetch there
    set_in(1'b1, 1'b1, 1'b1, 16'h0005, 1'b0, 16'h0000, 1'b1, 16'h0005, 16'h0020);
    cycle();
    chk("redir_addr", i_address, 16'h0005);
    set_in(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h5555, 1'b0, 16'h0000, 16'h0000);
    cycle();
    chk("btb_ir", ir, 16'h5555);
    chk("btb_pcn", ir_pc_next, 16'h0006);
`ifdef FETCH_BTB_EN
    chk("btb_pred", pred_taken, 1'b1);
    chk("btb_addr", i_address, 16'h0020);
`else
    chk("nobtb_pred", pred_taken, 1'b0);
    chk("nobtb_addr", i_address, 16'h0006);
`endif

    // Wrap at 0xFFFF
    set_in(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    cycle();
    set_in(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h7777, 1'b0, 16'h0000, 16'h0000);
    cycle();
    chk("wrap_ir", ir, 16'h7777);
    chk("wrap_addr", i_address, 16'h0000);
    chk("wrap_pcn", ir_pc_next, 16'h0000);

    // No data returned: bubble, PC unchanged
    set_in(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    cycle();
    chk("bubble_ir", ir, NOP);
    chk("bubble_valid", ir_valid, 1'b0);
    chk("bubble_addr", i_address, 16'h0000);

    // Randomized traffic with one asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2;
        reset_n = 1'b0; m_rst = 1'b1;
        model_reset();
        #1;
        compare();
        chk("midrst_pcn", ir_pc_next, 16'h0000);
        chk("midrst_pred", pred_taken, 1'b0);
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          drive_random();
          cycle();
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; m_rst = 1'b0;
      end
      drive_random();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
